// File: rtl/call_stack_ctrl.sv
// Return-address stack with level count, full/empty flags and sticky overflow/underflow errors.
// Optional high-water mark output (hi_mark) is built when CALL_STACK_HWM_EN is defined.
module call_stack_ctrl #(
  parameter  int NBITS = 9,
  parameter  int DEPTH = 5,
  localparam int LVLW  = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [NBITS-1:0] din,
  input  logic             clr_err,
  output logic [NBITS-1:0] top,
  output logic [LVLW-1:0]  level,
`ifdef CALL_STACK_HWM_EN
  output logic [LVLW-1:0]  hi_mark,
`endif
  output logic             empty,
  output logic             full,
  output logic             err_ovf,
  output logic             err_udf
);
  localparam int IDXW = $clog2(DEPTH);

  logic [DEPTH-1:0][NBITS-1:0] mem;
  logic [LVLW-1:0]             lvl, nxt_lvl;
  logic [IDXW-1:0]             top_idx, wr_idx;
  logic                        wr_en, ovf_ev, udf_ev;

  assign empty   = (lvl == '0);
  assign full    = (lvl == LVLW'(DEPTH));
  assign level   = lvl;
  assign top_idx = IDXW'(lvl - LVLW'(1));
  assign top     = empty ? '0 : mem[top_idx];

  always_comb begin
    nxt_lvl = lvl;
    wr_en   = 1'b0;
    wr_idx  = IDXW'(lvl);
    ovf_ev  = 1'b0;
    udf_ev  = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          wr_en   = 1'b1;
          nxt_lvl = lvl + LVLW'(1);
        end else ovf_ev = 1'b1;
      end
      2'b01: begin
        if (!empty) nxt_lvl = lvl - LVLW'(1);
        else        udf_ev  = 1'b1;
      end
      2'b11: begin
        wr_en = 1'b1;
        if (!empty) wr_idx = top_idx;
        else begin
          // push+pop on empty degenerates to a plain push, still an underflow
          wr_idx  = '0;
          nxt_lvl = LVLW'(1);
          udf_ev  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl     <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      lvl     <= nxt_lvl;
      err_ovf <= ovf_ev | (err_ovf & ~clr_err);
      err_udf <= udf_ev | (err_udf & ~clr_err);
    end
  end

`ifdef CALL_STACK_HWM_EN
  // reload uses the post-edge level so hi_mark >= level always holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    hi_mark <= '0;
    else if (clr_err)           hi_mark <= nxt_lvl;
    else if (nxt_lvl > hi_mark) hi_mark <= nxt_lvl;
  end
`endif

endmodule
